id_ex_debug_reader: RTL and testbench

Debug-path reader for the ID/EX pipeline latch. On a start request it snapshots every ID/EX output field in one cycle and streams the snapshot as a fixed 18-byte frame over a valid/ready byte interface toward the debug UART transmitter. It sits beside the ID/EX latch in the debug unit. It never drives the pipeline, so the pipeline may keep running after the snapshot edge.

---
 rtl/id_ex_debug_reader_if.sv | 9 +
 rtl/id_ex_debug_reader.sv | 117 +++++++++++
 tb/tb_id_ex_debug_reader.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_debug_reader_if.sv
// Byte-wide valid/ready stream carrying debug frames toward the UART transmitter.
interface id_ex_debug_reader_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/id_ex_debug_reader.sv
// Snapshots the ID/EX latch fields on a start request and streams them as an
// 18-byte frame (header + 17 payload bytes, MSB first) over a valid/ready link.
module id_ex_debug_reader #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         FRAME_BYTES = 18
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        aluSrc_i,
    input  logic        aluShiftImm_i,
    input  logic        regDst_i,
    input  logic        loadImm_i,
    input  logic        memToReg_i,
    input  logic        regWrite_i,
    input  logic        eop_i,
    input  logic [1:0]  memReadWidth_i,
    input  logic [3:0]  memWrite_i,
    input  logic [3:0]  aluControl_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  sa_i,
    input  logic [31:0] signImm_i,
    input  logic [31:0] readData1_i,
    input  logic [31:0] readData2_i,
    id_ex_debug_reader_if.master tx,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int         SNAP_W   = 133;
    localparam int         FRAME_W  = 8 * FRAME_BYTES;
    localparam logic [4:0] LAST_IDX = 5'(FRAME_BYTES - 1);

    logic [1:0]        state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [SNAP_W-1:0] snap_q, snap_d;

    logic [SNAP_W-1:0] fields;
    logic [FRAME_W-1:0] frame_bits;
    logic [7:0]        frame_bytes [FRAME_BYTES];
    logic              accept;

    // Field order matches the frame payload order, so the frame is just the
    // header, the snapshot, and three pad bits after sa.
    assign fields = {readData1_i, readData2_i, signImm_i,
                     aluControl_i, memWrite_i,
                     rs_i, memReadWidth_i, eop_i,
                     rt_i, regWrite_i, loadImm_i, regDst_i,
                     rd_i, memToReg_i, aluShiftImm_i, aluSrc_i,
                     sa_i};

    assign frame_bits = {HEADER, snap_q, 3'b000};

    generate
        for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_frame_byte
            assign frame_bytes[gi] = frame_bits[8*(FRAME_BYTES-gi)-1 -: 8];
        end
    endgenerate

    assign accept = (state_q == ST_SEND) && tx.tx_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    snap_d  = fields;
                    idx_d   = 5'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= 5'd0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them
    // without waiting for a clock edge.
    assign tx.tx_valid = (state_q == ST_SEND);
    assign tx.tx_data  = (state_q == ST_SEND) ? frame_bytes[idx_q] : 8'h00;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_id_ex_debug_reader.sv
// Directed bench for id_ex_debug_reader: frame content, latency, backpressure,
// snapshot isolation, asynchronous reset and back-to-back framing.
module tb_id_ex_debug_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        aluSrc, aluShiftImm, regDst, loadImm, memToReg, regWrite, eop;
    logic [1:0]  memReadWidth;
    logic [3:0]  memWrite, aluControl;
    logic [4:0]  rs, rt, rd, sa;
    logic [31:0] signImm, readData1, readData2;
    logic        busy, done;

    id_ex_debug_reader_if tx_if ();

    id_ex_debug_reader dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .aluSrc_i       (aluSrc),
        .aluShiftImm_i  (aluShiftImm),
        .regDst_i       (regDst),
        .loadImm_i      (loadImm),
        .memToReg_i     (memToReg),
        .regWrite_i     (regWrite),
        .eop_i          (eop),
        .memReadWidth_i (memReadWidth),
        .memWrite_i     (memWrite),
        .aluControl_i   (aluControl),
        .rs_i           (rs),
        .rt_i           (rt),
        .rd_i           (rd),
        .sa_i           (sa),
        .signImm_i      (signImm),
        .readData1_i    (readData1),
        .readData2_i    (readData2),
        .tx             (tx_if.master),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    int         vectors    = 0;
    int         miscompares = 0;
    logic [7:0] exp_q [18];
    logic [7:0] got_q [18];
    int         nbytes;
    int         done_cycle;
    int         unstable;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_fields();
        aluSrc = 1'($urandom); aluShiftImm = 1'($urandom); regDst = 1'($urandom);
        loadImm = 1'($urandom); memToReg = 1'($urandom); regWrite = 1'($urandom);
        eop = 1'($urandom); memReadWidth = 2'($urandom);
        memWrite = 4'($urandom); aluControl = 4'($urandom);
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sa = 5'($urandom);
        signImm = $urandom; readData1 = $urandom; readData2 = $urandom;
    endtask

    // Expected frame from the field values currently on the inputs.
    task automatic build_expected();
        exp_q[0] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            exp_q[1+i] = readData1[31-8*i -: 8];
            exp_q[5+i] = readData2[31-8*i -: 8];
            exp_q[9+i] = signImm[31-8*i -: 8];
        end
        exp_q[13] = {aluControl, memWrite};
        exp_q[14] = {rs, memReadWidth, eop};
        exp_q[15] = {rt, regWrite, loadImm, regDst};
        exp_q[16] = {rd, memToReg, aluShiftImm, aluSrc};
        exp_q[17] = {sa, 3'b000};
    endtask

    // Called at edge+1 in IDLE; returns at edge+1 just after the start edge.
    task automatic start_frame();
        build_expected();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Receiver loop: mode 0 = always ready, 1 = 5-cycle stall on byte 3 then
    // random ready, 2 = always ready while fields churn and start pulses mid-frame.
    task automatic run_frame(input int mode);
        logic       prev_stall;
        logic [7:0] prev_data;
        int         stall_left;
        nbytes = 0; done_cycle = -1; unstable = 0;
        prev_stall = 1'b0; prev_data = 8'h00; stall_left = 5;
        for (int c = 0; c < 400; c++) begin
            if (mode == 1) begin
                if (nbytes == 3 && stall_left > 0) begin
                    tx_if.tx_ready = 1'b0;
                    stall_left--;
                end else if (nbytes > 3) begin
                    tx_if.tx_ready = 1'($urandom_range(0, 1));
                end else begin
                    tx_if.tx_ready = 1'b1;
                end
            end else begin
                tx_if.tx_ready = 1'b1;
            end
            if (prev_stall && (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== prev_data))
                unstable++;
            if (done === 1'b1) begin
                done_cycle = c;
                break;
            end
            if (tx_if.tx_valid === 1'b1) begin
                if (tx_if.tx_ready) begin
                    if (nbytes < 18) got_q[nbytes] = tx_if.tx_data;
                    nbytes++;
                end
                prev_stall = !tx_if.tx_ready;
                prev_data  = tx_if.tx_data;
            end else begin
                prev_stall = 1'b0;
            end
            if (mode == 2) begin
                scramble_fields();
                start = (c == 5);
            end
            step();
        end
        start = 1'b0;
        tx_if.tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; tx_if.tx_ready = 1'b1;
        scramble_fields();
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({tx_if.tx_valid, tx_if.tx_data, busy, done} !== 11'd0) begin
                miscompares++;
                $display("FAIL reset_hold: valid=%b data=%h busy=%b done=%b, required all 0",
                         tx_if.tx_valid, tx_if.tx_data, busy, done);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({tx_if.tx_valid, tx_if.tx_data, busy, done} !== 11'd0) begin
                miscompares++;
                $display("FAIL reset_release: valid=%b data=%h busy=%b done=%b, required all 0",
                         tx_if.tx_valid, tx_if.tx_data, busy, done);
            end
        end
    endtask

    task automatic test_full_frame();
        logic [7:0] ref_bytes [18];
        ref_bytes = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                      8'hFF, 8'hFF, 8'h80, 8'h00, 8'hA3, 8'h0D, 8'h15, 8'hFD, 8'h20};
        readData1 = 32'h11223344; readData2 = 32'h55667788; signImm = 32'hFFFF8000;
        aluControl = 4'hA; memWrite = 4'h3; rs = 5'd1; memReadWidth = 2'b10; eop = 1'b1;
        rt = 5'd2; regWrite = 1'b1; loadImm = 1'b0; regDst = 1'b1;
        rd = 5'd31; memToReg = 1'b1; aluShiftImm = 1'b0; aluSrc = 1'b1; sa = 5'd4;
        start_frame();
        vectors++;
        if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'hA5 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL first_byte_latency: valid=%b data=%h busy=%b, required 1/a5/1",
                     tx_if.tx_valid, tx_if.tx_data, busy);
        end
        run_frame(0);
        for (int i = 0; i < 18; i++) begin
            vectors++;
            if (got_q[i] !== ref_bytes[i]) begin
                miscompares++;
                $display("FAIL full_frame byte %0d: got %h, required %h", i, got_q[i], ref_bytes[i]);
            end
        end
        vectors++;
        if (nbytes != 18 || done_cycle != 18) begin
            miscompares++;
            $display("FAIL full_frame_timing: bytes=%0d done_at=%0d, required 18/18", nbytes, done_cycle);
        end
        step();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_one_cycle: done=%b busy=%b, required 0/0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        start_frame();
        run_frame(1);
        vectors++;
        if (unstable != 0 || nbytes != 18) begin
            miscompares++;
            $display("FAIL backpressure_stability: unstable=%0d bytes=%0d, required 0/18", unstable, nbytes);
        end
        for (int i = 0; i < 18; i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL backpressure byte %0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        step();
    endtask

    task automatic test_snapshot_isolation();
        scramble_fields();
        start_frame();
        run_frame(2);
        for (int i = 0; i < 18; i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL snapshot byte %0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (nbytes != 18 || done_cycle != 18) begin
            miscompares++;
            $display("FAIL snapshot_timing: bytes=%0d done_at=%0d, required 18/18", nbytes, done_cycle);
        end
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_start_ignored: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        scramble_fields();
        start_frame();
        tx_if.tx_ready = 1'b1;
        repeat (9) step();
        vectors++;
        if (tx_if.tx_data !== exp_q[9]) begin
            miscompares++;
            $display("FAIL pre_reset_byte9: got %h, required %h", tx_if.tx_data, exp_q[9]);
        end
        rst_n = 1'b0;
        #2;
        vectors++;
        if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || tx_if.tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b busy=%b data=%h, required 0/0/00",
                     tx_if.tx_valid, busy, tx_if.tx_data);
        end
        step();
        rst_n = 1'b1;
        step(); step();
        vectors++;
        if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL no_resume: busy=%b valid=%b, required 0/0", busy, tx_if.tx_valid);
        end
        scramble_fields();
        start_frame();
        run_frame(0);
        for (int i = 0; i < 18; i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL post_reset_frame byte %0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int  rise [3];
        int  nrise;
        int  idle_between;
        logic prev_busy;
        nrise = 0; idle_between = 0; prev_busy = 1'b0;
        scramble_fields();
        tx_if.tx_ready = 1'b1;
        start = 1'b1;
        for (int t = 0; t < 50; t++) begin
            step();
            if (busy === 1'b1 && !prev_busy && nrise < 3) begin
                rise[nrise] = t;
                nrise++;
            end
            if (busy === 1'b0 && nrise == 1) idle_between++;
            prev_busy = busy;
        end
        start = 1'b0;
        vectors++;
        if (nrise != 3 || rise[1] - rise[0] != 20 || rise[2] - rise[1] != 20) begin
            miscompares++;
            $display("FAIL b2b_period: frames=%0d starts=%0d,%0d,%0d, required 3 frames 20 apart",
                     nrise, rise[0], rise[1], rise[2]);
        end
        vectors++;
        if (idle_between != 1) begin
            miscompares++;
            $display("FAIL b2b_idle_gap: idle cycles=%0d, required 1", idle_between);
        end
        for (int t = 0; t < 40 && busy === 1'b1; t++) step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: busy=%b after drain bound, required 0", busy);
        end
    endtask

    initial begin
        tx_if.tx_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_snapshot_isolation();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
